// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC unit: issues fetch addresses to a multi-cycle instruction memory,
// applies exception/eret/branch redirects and drives the F/D boundary register.
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [ADDR_W-1:0] IMEM_LO    = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] IMEM_HI    = 32'h0000_6ffc
) (
  input  logic              i_clk,
  input  logic              i_reset,       // active-low, asynchronous
  input  logic              i_stall,
  input  logic              i_exc_req,
  input  logic              i_eret,
  input  logic [ADDR_W-1:0] i_epc,
  input  logic              i_br_valid,
  input  logic [ADDR_W-1:0] i_br_target,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [ADDR_W-1:0] i_imem_rdata,
  output logic              o_instr_valid,
  output logic [ADDR_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc_f,
  output logic              o_adel
);

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] PC_STEP   = {{(ADDR_W-3){1'b0}}, 3'b100};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DROP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [ADDR_W-1:0] w_imem_addr_next;
  logic              r_instr_valid;
  logic              w_instr_valid_next;
  logic [ADDR_W-1:0] r_instr;
  logic [ADDR_W-1:0] w_instr_next;
  logic [ADDR_W-1:0] r_pc_f;
  logic [ADDR_W-1:0] w_pc_f_next;
  logic              r_adel;
  logic              w_adel_next;

  logic              w_redirect;
  logic [ADDR_W-1:0] w_target;
  logic              w_pc_bad;
  logic              w_can_issue;
  logic              w_consume;

  assign w_redirect  = i_exc_req | i_eret | i_br_valid;
  assign w_pc_bad    = (r_pc[1:0] != 2'b00) || (r_pc < IMEM_LO) || (r_pc > IMEM_HI);
  assign w_can_issue = !r_instr_valid || !i_stall;
  assign w_consume   = r_instr_valid && !i_stall;

  always_comb begin
    w_target = i_br_target;
    if (i_exc_req) begin
      w_target = EXC_VECTOR;
    end else if (i_eret) begin
      w_target = i_epc & WORD_MASK;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_redirect && w_can_issue) begin
          w_state_next = w_pc_bad ? S_ERR : S_BUSY;
        end
      end
      S_BUSY: begin
        if (i_imem_ack) begin
          w_state_next = S_IDLE;
        end else if (w_redirect) begin
          w_state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (i_imem_ack) begin
          w_state_next = S_IDLE;
        end
      end
      S_ERR: begin
        if (w_redirect) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The faulting entry in ERR is held even without stall; everything else is consumed.
  always_comb begin
    w_pc_next          = r_pc;
    w_imem_addr_next   = r_imem_addr;
    w_instr_valid_next = r_instr_valid && !(w_consume && (r_state != S_ERR));
    w_instr_next       = r_instr;
    w_pc_f_next        = r_pc_f;
    w_adel_next        = r_adel;

    if (w_redirect) begin
      w_pc_next          = w_target;
      w_instr_valid_next = 1'b0;
      w_adel_next        = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_can_issue) begin
            if (w_pc_bad) begin
              w_instr_valid_next = 1'b1;
              w_instr_next       = '0;
              w_pc_f_next        = r_pc;
              w_adel_next        = 1'b1;
            end else begin
              w_imem_addr_next   = r_pc;
            end
          end
        end
        S_BUSY: begin
          if (i_imem_ack) begin
            w_instr_valid_next = 1'b1;
            w_instr_next       = i_imem_rdata;
            w_pc_f_next        = r_imem_addr;
            w_adel_next        = 1'b0;
            w_pc_next          = r_imem_addr + PC_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pc          <= RESET_PC;
      r_imem_addr   <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_pc_f        <= RESET_PC;
      r_adel        <= 1'b0;
    end else begin
      r_pc          <= w_pc_next;
      r_imem_addr   <= w_imem_addr_next;
      r_instr_valid <= w_instr_valid_next;
      r_instr       <= w_instr_next;
      r_pc_f        <= w_pc_f_next;
      r_adel        <= w_adel_next;
    end
  end

  assign o_imem_req    = (r_state == S_BUSY) || (r_state == S_DROP);
  assign o_imem_addr   = r_imem_addr;
  assign o_instr_valid = r_instr_valid;
  assign o_instr       = r_instr;
  assign o_pc_f        = r_pc_f;
  assign o_adel        = r_adel;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed redirect/fault/reset scenarios, then random
// stall/latency/redirect traffic scored against an in-order fetch-stream model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, exc_req, eret, br_valid;
  logic [31:0] epc, br_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, adel;
  logic [31:0] instr, pc_f;

  int          total = 0;
  int          bad   = 0;
  int          pops  = 0;
  int          mem_min = 0;
  int          mem_max = 0;
  bit          mon_en  = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_stall      (stall),
    .i_exc_req    (exc_req),
    .i_eret       (eret),
    .i_epc        (epc),
    .i_br_valid   (br_valid),
    .i_br_target  (br_target),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .o_instr_valid(instr_valid),
    .o_instr      (instr),
    .o_pc_f       (pc_f),
    .o_adel       (adel)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic wait_req(input logic lvl, input string name);
    int n = 0;
    while (imem_req !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== lvl) begin
      total++;
      bad++;
      $display("FAIL %s timeout actual=%b required=%b", name, imem_req, lvl);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (instr_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s timeout actual=%b required=1", name, instr_valid);
    end
  endtask

  // Memory: random latency per request, junk on rdata when not acking.
  initial begin
    int  cnt = 0;
    bit  pend = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rdata = $urandom;
      if (rst_n !== 1'b1 || imem_req !== 1'b1) begin
        imem_ack = 1'b0;
        pend     = 1'b0;
      end else begin
        if (!pend) begin
          pend = 1'b1;
          cnt  = int'($urandom_range(mem_max, mem_min));
        end
        if (cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          pend       = 1'b0;
        end else begin
          imem_ack = 1'b0;
          cnt--;
        end
      end
    end
  end

  // Monitor: pops the expected stream on each newly presented F/D entry.
  initial begin
    logic        prev_valid = 1'b0, prev_stall = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_pc = '0, prev_instr = '0, prev_addr = '0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!mon_en || rst_n !== 1'b1) begin
        prev_valid = 1'b0;
        prev_req   = 1'b0;
      end else begin
        if (prev_req && !prev_ack && imem_req)
          check("addr_stable", imem_addr, prev_addr);
        if (prev_valid && !prev_stall)
          check1("consume", instr_valid, 1'b0);
        if (prev_valid && prev_stall && instr_valid) begin
          check("hold_pc_f", pc_f, prev_pc);
          check("hold_instr", instr, prev_instr);
        end
        if (instr_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty actual_pc_f=%h required=none", pc_f);
          end else begin
            e = exp_q.pop_front();
            pops++;
            check("entry_pc_f", pc_f, e);
            check("entry_instr", instr, mem_word(e));
            check1("entry_adel", adel, 1'b0);
            $display("entry pc_f=%h instr=%h expected_pc=%h", pc_f, instr, e);
          end
        end
        prev_valid = instr_valid;
        prev_stall = stall;
        prev_pc    = pc_f;
        prev_instr = instr;
        prev_req   = imem_req;
        prev_ack   = imem_ack;
        prev_addr  = imem_addr;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] tgts[3];
    logic [31:0] pend_target;
    bit          pend_flush;
    logic [2:0]  sel;
    int          n;

    rst_n = 1'b0; stall = 1'b0; exc_req = 1'b0; eret = 1'b0; br_valid = 1'b0;
    epc = '0; br_target = '0;
    repeat (2) @(negedge clk);
    check1("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, RESET_PC);
    check1("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc_f", pc_f, RESET_PC);
    check1("rst_adel", adel, 1'b0);

    // Sequential fetch, then a stall held over the first entry.
    @(posedge clk); #1 rst_n = 1'b1; stall = 1'b1;
    wait_req(1'b1, "t1_req0");
    check("t1_addr0", imem_addr, 32'h3000);
    wait_valid("t1_valid0");
    check("t1_pc_f0", pc_f, 32'h3000);
    check("t1_instr0", instr, mem_word(32'h3000));
    check1("t1_adel0", adel, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_pc_f", pc_f, 32'h3000);
      check("t2_hold_instr", instr, mem_word(32'h3000));
      check1("t2_no_req", imem_req, 1'b0);
    end
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check1("t2_req_after_stall", imem_req, 1'b1);
    check("t2_addr1", imem_addr, 32'h3004);
    wait_valid("t1_valid1");
    check("t1_pc_f1", pc_f, 32'h3004);
    check("t1_instr1", instr, mem_word(32'h3004));
    wait_req(1'b1, "t1_req2");
    check("t1_addr2", imem_addr, 32'h3008);
    mem_min = 3; mem_max = 3;

    // Branch while a slow fetch at 0x3010 is outstanding.
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === 32'h3010) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t3_busy_addr", imem_addr, 32'h3010);
    @(posedge clk); #1 br_valid = 1'b1; br_target = 32'h3400;
    @(posedge clk); #1 br_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (imem_req === 1'b1 && n < 10) begin
      check("t3_addr_held", imem_addr, 32'h3010);
      check1("t3_flushed", instr_valid, 1'b0);
      @(negedge clk);
      n++;
    end
    wait_req(1'b1, "t3_req");
    check("t3_new_addr", imem_addr, 32'h3400);
    check1("t3_valid_meanwhile", instr_valid, 1'b0);
    wait_valid("t3_valid");
    check("t3_pc_f", pc_f, 32'h3400);
    check("t3_instr", instr, mem_word(32'h3400));

    // Redirect priority.
    mem_min = 0; mem_max = 2;
    @(posedge clk); #1 exc_req = 1'b1; eret = 1'b1; epc = 32'h3021; br_valid = 1'b1; br_target = 32'h3400;
    @(posedge clk); #1 exc_req = 1'b0; eret = 1'b0; br_valid = 1'b0;
    check1("t4_flush", instr_valid, 1'b0);
    wait_req(1'b0, "t4_drain");
    wait_req(1'b1, "t4_req");
    check("t4_exc_addr", imem_addr, EXC_VEC);
    wait_valid("t4_valid");
    check("t4_pc_f", pc_f, EXC_VEC);
    @(posedge clk); #1 eret = 1'b1; epc = 32'h3021;
    @(posedge clk); #1 eret = 1'b0;
    wait_req(1'b0, "t4_drain2");
    wait_req(1'b1, "t4_req2");
    check("t4_eret_addr", imem_addr, 32'h3020);

    // Fetch address errors, recovered by an exception.
    tgts[0] = 32'h3002; tgts[1] = 32'h7000; tgts[2] = 32'h2ffc;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1 br_valid = 1'b1; br_target = tgts[t];
      @(posedge clk); #1 br_valid = 1'b0;
      wait_valid("t5_valid");
      check1("t5_adel", adel, 1'b1);
      check("t5_instr", instr, 32'h0);
      check("t5_pc_f", pc_f, tgts[t]);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check1("t5_no_req", imem_req, 1'b0);
        check1("t5_held_valid", instr_valid, 1'b1);
        check("t5_held_pc_f", pc_f, tgts[t]);
      end
      @(posedge clk); #1 exc_req = 1'b1;
      @(posedge clk); #1 exc_req = 1'b0;
      check1("t5_adel_clr", adel, 1'b0);
      check1("t5_valid_clr", instr_valid, 1'b0);
      wait_req(1'b1, "t5_req");
      check("t5_exc_addr", imem_addr, EXC_VEC);
    end

    // Last legal word, then sequential step into the fault region.
    @(posedge clk); #1 br_valid = 1'b1; br_target = 32'h6ffc;
    @(posedge clk); #1 br_valid = 1'b0;
    wait_req(1'b0, "hi_drain");
    wait_req(1'b1, "hi_req");
    check("hi_addr", imem_addr, 32'h6ffc);
    wait_valid("hi_valid");
    check("hi_pc_f", pc_f, 32'h6ffc);
    check1("hi_adel", adel, 1'b0);
    @(negedge clk);
    check("hi_next_pc_f", pc_f, 32'h7000);
    check1("hi_next_adel", adel, 1'b1);
    check1("hi_next_no_req", imem_req, 1'b0);

    // Reset while a request is outstanding.
    mem_min = 5; mem_max = 5;
    @(posedge clk); #1 exc_req = 1'b1;
    @(posedge clk); #1 exc_req = 1'b0;
    wait_req(1'b1, "t6_busy");
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check1("t6_req_async", imem_req, 1'b0);
    check1("t6_valid", instr_valid, 1'b0);
    check("t6_addr", imem_addr, RESET_PC);
    @(negedge clk); rst_n = 1'b1;
    wait_req(1'b1, "t6_req");
    check("t6_refetch", imem_addr, RESET_PC);

    // Random traffic against the fetch-stream model.
    @(negedge clk); rst_n = 1'b0;
    mem_min = 0; mem_max = 3;
    exp_q.delete();
    model_pc   = RESET_PC;
    pend_flush = 1'b0;
    pend_target = '0;
    while (exp_q.size() < 8) begin exp_q.push_back(model_pc); model_pc += 32'd4; end
    @(negedge clk); rst_n = 1'b1; mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (pend_flush) begin
        exp_q.delete();
        model_pc   = pend_target;
        pend_flush = 1'b0;
      end
      while (exp_q.size() < 8) begin exp_q.push_back(model_pc); model_pc += 32'd4; end
      exc_req = 1'b0; eret = 1'b0; br_valid = 1'b0;
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) < 6) begin
        sel       = 3'($urandom_range(1, 7));
        exc_req   = sel[0];
        eret      = sel[1];
        br_valid  = sel[2];
        epc       = 32'h3000 + 32'($urandom_range(0, 32'h2fff));
        br_target = (32'h3000 + 32'($urandom_range(0, 32'h2ff0))) & 32'hffff_fffc;
        if (exc_req)   pend_target = EXC_VEC;
        else if (eret) pend_target = {epc[31:2], 2'b00};
        else           pend_target = br_target;
        pend_flush = 1'b1;
      end
    end
    @(posedge clk); #1 exc_req = 1'b0; eret = 1'b0; br_valid = 1'b0; stall = 1'b0;
    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    check1("rand_progress", pops > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
